// File: rtl/riscv_wb_pkg.sv
// Shared types and constants for the MEM/WB stage.
// Build option: WB_RETIRE_CNT_EN enables the retire counter.
package riscv_wb_pkg;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake and payload bundle.
// Build option: WB_RETIRE_CNT_EN (no effect on this file).
interface wb_stage_if
  import riscv_wb_pkg::*;
#(
  parameter int XLEN  = riscv_wb_pkg::XLEN,
  parameter int RF_AW = riscv_wb_pkg::RF_AW
) ();

  logic             mem_valid_i;
  logic             mem_ready_o;
  logic [RF_AW-1:0] rd_addr_i;
  logic             reg_write_i;
  logic [1:0]       wb_sel_i;
  logic [2:0]       load_funct3_i;
  logic [1:0]       addr_lo_i;
  logic [XLEN-1:0]  alu_result_i;
  logic [XLEN-1:0]  mem_rdata_i;
  logic [XLEN-1:0]  pc_plus4_i;

  modport master (
    output mem_valid_i,
    input  mem_ready_o,
    output rd_addr_i,
    output reg_write_i,
    output wb_sel_i,
    output load_funct3_i,
    output addr_lo_i,
    output alu_result_i,
    output mem_rdata_i,
    output pc_plus4_i
  );

  modport slave (
    input  mem_valid_i,
    output mem_ready_o,
    input  rd_addr_i,
    input  reg_write_i,
    input  wb_sel_i,
    input  load_funct3_i,
    input  addr_lo_i,
    input  alu_result_i,
    input  mem_rdata_i,
    input  pc_plus4_i
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Load data lane select and sign/zero extension.
// Build option: WB_RETIRE_CNT_EN (no effect on this file).
module load_align
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = riscv_wb_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half from the raw word.
  always_comb begin
    byte_sel = raw[7:0];
    unique case (addr_lo)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = addr_lo[1] ? raw[31:16]
                          : raw[15:0];
  end

  // Extend by load type; unknown types read 0.
  always_comb begin
    ext = '0;
    unique case (1'b1)
      (funct3 == F3_LB):
        ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      (funct3 == F3_LBU):
        ext = {{(XLEN-8){1'b0}}, byte_sel};
      (funct3 == F3_LH):
        ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      (funct3 == F3_LHU):
        ext = {{(XLEN-16){1'b0}}, half_sel};
      (funct3 == F3_LW):
        ext = raw;
      default:
        ext = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB register stage driving the register-file write port.
// Build option: WB_RETIRE_CNT_EN adds a 64-bit retire counter.
module wb_stage
  import riscv_wb_pkg::*;
#(
  parameter int XLEN  = riscv_wb_pkg::XLEN,
  parameter int RF_AW = riscv_wb_pkg::RF_AW
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_if.slave        mem,
  input  logic             flush_i,
  input  logic             wb_hold_i,
  output logic [RF_AW-1:0] RDaddr_o,
  output logic [XLEN-1:0]  RDdata_o,
  output logic             RegWrite_o,
  output logic             wb_valid_o,
  output logic [63:0]      retire_cnt_o
);

  logic             valid_q;
  logic             rw_q;
  logic [RF_AW-1:0] rd_q;
  logic [XLEN-1:0]  data_q;

  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  wb_data;
  logic             capture;
  logic             writes;

  assign mem.mem_ready_o = ~wb_hold_i;
  assign capture = mem.mem_valid_i
                 & ~wb_hold_i
                 & ~flush_i;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3  (mem.load_funct3_i),
    .addr_lo (mem.addr_lo_i),
    .raw     (mem.mem_rdata_i),
    .ext     (load_data)
  );

  // Writeback source mux ahead of the stage flop.
  always_comb begin
    wb_data = '0;
    unique case (wb_sel_e'(mem.wb_sel_i))
      WB_ALU:  wb_data = mem.alu_result_i;
      WB_MEM:  wb_data = load_data;
      WB_PC4:  wb_data = mem.pc_plus4_i;
      WB_RSVD: wb_data = '0;
      default: wb_data = '0;
    endcase
  end

  // Stage register: hold freezes, else capture or bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else if (!wb_hold_i) begin
      if (capture) begin
        valid_q <= 1'b1;
        rw_q    <= mem.reg_write_i;
        rd_q    <= mem.rd_addr_i;
        data_q  <= wb_data;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign writes     = valid_q & rw_q & (rd_q != '0);
  assign wb_valid_o = writes;
  assign RegWrite_o = writes & ~wb_hold_i;
  assign RDaddr_o   = rd_q;
  assign RDdata_o   = data_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] cnt_q;

  // Count every instruction that leaves the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (valid_q && !wb_hold_i) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign retire_cnt_o = cnt_q;
`else
  assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
// Build option: WB_RETIRE_CNT_EN selects the counter checks.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        wb_hold_i;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        RegWrite_o;
  logic        wb_valid_o;
  logic [63:0] retire_cnt_o;

  int checks = 0;
  int errors = 0;

  wb_stage_if #(.XLEN(32), .RF_AW(5)) mif ();

  wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .mem          (mif.slave),
    .flush_i      (flush_i),
    .wb_hold_i    (wb_hold_i),
    .RDaddr_o     (RDaddr_o),
    .RDdata_o     (RDdata_o),
    .RegWrite_o   (RegWrite_o),
    .wb_valid_o   (wb_valid_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       t,
    input logic [63:0] o,
    input logic [63:0] e
  );
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h",
             t, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [4:0]  rd,
    input logic        rw,
    input logic [1:0]  sel,
    input logic [2:0]  f3,
    input logic [1:0]  lo,
    input logic [31:0] alu,
    input logic [31:0] rdata,
    input logic [31:0] pc4
  );
    mif.mem_valid_i   = 1'b1;
    mif.rd_addr_i     = rd;
    mif.reg_write_i   = rw;
    mif.wb_sel_i      = sel;
    mif.load_funct3_i = f3;
    mif.addr_lo_i     = lo;
    mif.alu_result_i  = alu;
    mif.mem_rdata_i   = rdata;
    mif.pc_plus4_i    = pc4;
  endtask

  localparam logic [31:0] RW = 32'h8081F2F3;

  initial begin
    rst       = 1'b1;
    flush_i   = 1'b0;
    wb_hold_i = 1'b0;
    drive(5'd0, 1'b0, 2'b00, 3'b000, 2'd0,
          32'h0, 32'h0, 32'h0);
    mif.mem_valid_i = 1'b0;
    step();
    step();
    chk("rst_we",    RegWrite_o, 1'b0);
    chk("rst_addr",  RDaddr_o, 5'd0);
    chk("rst_data",  RDdata_o, 32'h0);
    chk("rst_vld",   wb_valid_o, 1'b0);
    chk("rst_cnt",   retire_cnt_o, 64'd0);
    chk("rst_ready", mif.mem_ready_o, 1'b1);
    rst = 1'b0;

    drive(5'd5, 1'b1, 2'b01, 3'b000, 2'd1,
          32'h0, RW, 32'h0);
    step();
    chk("lb_data", RDdata_o, 32'hFFFFFFF2);
    chk("lb_addr", RDaddr_o, 5'd5);
    chk("lb_we",   RegWrite_o, 1'b1);
    chk("lb_vld",  wb_valid_o, 1'b1);
    drive(5'd6, 1'b1, 2'b01, 3'b100, 2'd1,
          32'h0, RW, 32'h0);
    step();
    chk("lbu_data", RDdata_o, 32'h000000F2);
    chk("lbu_addr", RDaddr_o, 5'd6);
    drive(5'd7, 1'b1, 2'b01, 3'b001, 2'd2,
          32'h0, RW, 32'h0);
    step();
    chk("lh_data", RDdata_o, 32'hFFFF8081);
    drive(5'd8, 1'b1, 2'b01, 3'b101, 2'd2,
          32'h0, RW, 32'h0);
    step();
    chk("lhu_data", RDdata_o, 32'h00008081);
    drive(5'd9, 1'b1, 2'b01, 3'b010, 2'd3,
          32'h0, RW, 32'h0);
    step();
    chk("lw_data", RDdata_o, 32'h8081F2F3);
    chk("lw_we",   RegWrite_o, 1'b1);
    drive(5'd9, 1'b1, 2'b01, 3'b011, 2'd0,
          32'h0, RW, 32'h0);
    step();
    chk("badf3_data", RDdata_o, 32'h0);

    drive(5'd1, 1'b1, 2'b10, 3'b000, 2'd0,
          32'h55, RW, 32'h00000104);
    step();
    chk("pc4_data", RDdata_o, 32'h00000104);
    chk("pc4_we",   RegWrite_o, 1'b1);
    drive(5'd0, 1'b1, 2'b00, 3'b000, 2'd0,
          32'h123, RW, 32'h104);
    step();
    chk("x0_we",   RegWrite_o, 1'b0);
    chk("x0_vld",  wb_valid_o, 1'b0);
    chk("x0_data", RDdata_o, 32'h123);
    drive(5'd2, 1'b1, 2'b11, 3'b000, 2'd0,
          32'h123, RW, 32'h104);
    step();
    chk("rsvd_data", RDdata_o, 32'h0);
    drive(5'd3, 1'b0, 2'b00, 3'b000, 2'd0,
          32'h77, RW, 32'h104);
    step();
    chk("norw_we", RegWrite_o, 1'b0);

    mif.mem_valid_i = 1'b0;
    step();
    chk("bub_we", RegWrite_o, 1'b0);
    drive(5'd3, 1'b1, 2'b00, 3'b000, 2'd0,
          32'h99, RW, 32'h104);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_we",  RegWrite_o, 1'b0);
    chk("flush_vld", wb_valid_o, 1'b0);

    drive(5'd7, 1'b1, 2'b00, 3'b000, 2'd0,
          32'hDEADBEEF, RW, 32'h104);
    step();
    chk("pre_hold_we", RegWrite_o, 1'b1);
    wb_hold_i = 1'b1;
    flush_i   = 1'b1;
    drive(5'd8, 1'b1, 2'b00, 3'b000, 2'd0,
          32'h11111111, RW, 32'h104);
    #1;
    chk("hold_ready", mif.mem_ready_o, 1'b0);
    chk("hold_we0",   RegWrite_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_we",   RegWrite_o, 1'b0);
      chk("hold_addr", RDaddr_o, 5'd7);
      chk("hold_data", RDdata_o, 32'hDEADBEEF);
      chk("hold_vld",  wb_valid_o, 1'b1);
    end
    wb_hold_i       = 1'b0;
    flush_i         = 1'b0;
    mif.mem_valid_i = 1'b0;
    #1;
    chk("rel_we",   RegWrite_o, 1'b1);
    chk("rel_data", RDdata_o, 32'hDEADBEEF);
    step();
    chk("rel_once", RegWrite_o, 1'b0);

    drive(5'd9, 1'b1, 2'b00, 3'b000, 2'd0,
          32'hCAFE, RW, 32'h104);
    step();
    chk("mid_we", RegWrite_o, 1'b1);
    rst = 1'b1;
    step();
    chk("mrst_we",   RegWrite_o, 1'b0);
    chk("mrst_addr", RDaddr_o, 5'd0);
    chk("mrst_data", RDdata_o, 32'h0);
    chk("mrst_vld",  wb_valid_o, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(5'(i + 1), 1'b1, 2'b00, 3'b000,
            2'd0, 32'(i), RW, 32'h104);
      flush_i = (i == 3) || (i == 6);
      if (i == 5) begin
        wb_hold_i = 1'b1;
        step();
        wb_hold_i = 1'b0;
      end
      step();
    end
    flush_i         = 1'b0;
    mif.mem_valid_i = 1'b0;
    step();
    step();
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_8", retire_cnt_o, 64'd8);
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cnt_q;
    drive(5'd4, 1'b1, 2'b00, 3'b000, 2'd0,
          32'h1, RW, 32'h104);
    step();
    chk("cnt_max", retire_cnt_o,
        64'hFFFF_FFFF_FFFF_FFFF);
    mif.mem_valid_i = 1'b0;
    step();
    chk("cnt_wrap", retire_cnt_o, 64'd0);
`else
    chk("cnt_off", retire_cnt_o, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
